i2c_slave_duplex: RTL and testbench
===================================

Name: i2c_slave_duplex

Overview:
- Parametrised next-generation I2C target, sitting directly behind the pad logic.
- Supports both master-write (RX) and master-read (TX) transfers; both directions are buffered by FIFOs.
- Adds a configurable address, a configurable FIFO depth, NACK-on-full flow control, repeated START, and underrun/overrun flags.
- The system side sees two FWFT FIFO interfaces.

Parameters:
- SLAVE_ADDR, 7'h78, 7-bit bus address the block responds to.
- TX_DEPTH, 8, TX FIFO entries; power of two, >= 2.
- RX_DEPTH, 8, RX FIFO entries; power of two, >= 2.
- UNDERRUN_BYTE, 8'hFF, byte sent when the TX FIFO is empty during a read.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- n_rst, input, 1, synchronous active-low reset, sampled on the clk rising edge.
- scl, input, 1, raw bus clock.
- sda_in, input, 1, raw bus data.
- sda_out, output, 1, 0 = drive SDA low, 1 = release.
- write_enable, input, 1, push write_data into the TX FIFO.
- write_data, input, 8, TX byte.
- tx_fifo_empty, output, 1, TX FIFO empty.
- tx_fifo_full, output, 1, TX FIFO full.
- read_enable, input, 1, pop the RX FIFO head.
- read_data, output, 8, RX FIFO head (fall-through).
- rx_fifo_empty, output, 1, RX FIFO empty.
- rx_fifo_full, output, 1, RX FIFO full.
- tx_underrun, output, 1, one-cycle pulse when UNDERRUN_BYTE is loaded.
- rx_overrun, output, 1, one-cycle pulse when a byte is NACKed because the RX FIFO is full.
- busy, output, 1, high from an addressed START until STOP or NACK exit.

Behaviour:
- Reset (n_rst=0 at a clk edge):
  - FSM goes to IDLE; both FIFOs are emptied.
  - Outputs: sda_out=1, both *_empty=1, both *_full=0, read_data=0, pulses=0, busy=0.
  - Reset mid-transfer releases SDA on the next clk edge; the bus transaction is abandoned.
- Input path:
  - scl and sda_in each pass through a 2-flop synchroniser, then a registered edge detect.
  - Every bus event acts 3 clk cycles after the pin change.
- Bus events:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Detection has priority over bit sampling in the same cycle.
- Bit timing:
  - Data is sampled on SCL rising edges.
  - sda_out changes only on SCL falling edges (or on STOP/START/reset).
- FSM states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACKCHK, WAIT_STOP.
- START from any state: clear the bit counter, go to ADDR. This covers repeated START.
- STOP from any state: go to IDLE, set sda_out=1, set busy=0.
- ADDR:
  - Shift in 8 bits MSB first.
  - Match when byte[7:1]==SLAVE_ADDR; rw=byte[0].
  - Match: go to ADDR_ACK and set busy=1.
  - Mismatch: go to WAIT_STOP; SDA stays released.
- ADDR_ACK:
  - sda_out=0 from the falling edge after bit 8 until the next falling edge.
  - rw=0: go to RX_BYTE.
  - rw=1: pop the TX FIFO at the ACK-ending falling edge, load the shifter, go to TX_BYTE. If the FIFO is empty, load UNDERRUN_BYTE and pulse tx_underrun.
- RX_BYTE:
  - Shift 8 bits; on the 8th rising edge, evaluate RX FIFO space.
  - Space available: push the byte on that cycle, go to RX_ACK (drive 0 for the 9th bit), then return to RX_BYTE.
  - Full: do not push, pulse rx_overrun, release SDA (NACK) for the 9th bit, then go to WAIT_STOP.
- TX_BYTE:
  - Drive shifter bit 7 (0 → 0, 1 → release), shift left on each SCL falling edge.
  - After 8 bits, release SDA and go to TX_ACKCHK.
- TX_ACKCHK: sample SDA on the 9th rising edge.
  - 0 (ACK): pop/load the next byte at the following falling edge (underrun rule applies), go to TX_BYTE.
  - 1 (NACK): go to WAIT_STOP.
- WAIT_STOP: SDA released; wait for STOP or START.
- FIFOs:
  - Circular, with pointer wrap at DEPTH and counts of width $clog2(DEPTH)+1.
  - A push while full is ignored; a pop while empty is ignored (state unchanged).
  - Simultaneous push and pop are both honoured; the count is unchanged and the push goes in after the current head.
  - Flags are registered and consistent with the count in the same cycle.
- Contention: a system read_enable coincident with an FSM RX push is legal; likewise write_enable with an FSM TX pop.

Decomposition:
- Package i2c_duplex_pkg:
  - State enum state_t.
  - Constants I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_BITS=8.
- Sub-module i2c_sync_fifo (parameters DEPTH, WIDTH=8), instantiated twice (TX, RX).
- Synchroniser, edge/START/STOP detect and FSM stay inline.

Test Plan:
- Write transfer: addr 0x78+W, bytes 0xA5, 0x3C, STOP → ACKs on address and both bytes; read_data gives 0xA5 then 0x3C; busy returns to 0.
- Read transfer: preload 0x12, 0x34; addr 0x78+R; master ACKs then NACKs → SDA carries 0x12, 0x34 MSB first; tx_fifo_empty=1 at the end; no tx_underrun.
- Address mismatch: addr 0x55+W → SDA never driven low; FIFOs untouched; busy stays 0.
- RX full (RX_DEPTH=2): write 3 bytes → first two ACKed; third NACKed with one rx_overrun pulse; RX FIFO still holds the first two.
- TX empty read plus repeated START: read with empty FIFO → 0xFF on SDA and tx_underrun pulse; repeated START then write addr → re-addressed correctly.
- Reset mid-TX-byte: n_rst low for 1 cycle → sda_out=1 the next edge; all flags are at reset values.

Source files
------------

// File: rtl/i2c_duplex_pkg.sv
// Shared types and bus constants for the duplex I2C target.
// FSM state encoding plus ACK/NACK levels and byte length.
package i2c_duplex_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACKCHK,
    WAIT_STOP
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int   I2C_BITS = 8;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Circular first-word-fall-through FIFO with registered flags.
// Head reads as zero while empty.
module i2c_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (do_push && !do_pop) count_n = count + CW'(1);
    if (do_pop && !do_push) count_n = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      empty <= (count_n == '0);
      full  <= (count_n == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2c_slave_duplex.sv
// I2C target with FIFO-buffered master-write and master-read paths.
// Bus pins are synchronised, edge-detected, then drive a bit-level FSM.
module i2c_slave_duplex
  import i2c_duplex_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR    = 7'h78,
  parameter int         TX_DEPTH      = 8,
  parameter int         RX_DEPTH      = 8,
  parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic       write_enable,
  input  logic [7:0] write_data,
  output logic       tx_fifo_empty,
  output logic       tx_fifo_full,
  input  logic       read_enable,
  output logic [7:0] read_data,
  output logic       rx_fifo_empty,
  output logic       rx_fifo_full,
  output logic       tx_underrun,
  output logic       rx_overrun,
  output logic       busy
);

  logic scl_s1, scl_s2, scl_s3;
  logic sda_s1, sda_s2, sda_s3;
  logic scl_rise, scl_fall;
  logic start_det, stop_det;
  logic sda_bit;

  state_t     state, state_n;
  logic [3:0] bit_cnt, cnt_n;
  logic [7:0] shreg, sh_n;
  logic       rw, rw_n;
  logic       sda_q, sda_n;
  logic       busy_q, busy_n;
  logic       under_q, under_n;
  logic       over_q, over_n;

  logic       tx_pop;
  logic [7:0] tx_head;
  logic       rx_push;
  logic [7:0] rx_byte;
  logic [7:0] load_byte;
  logic       do_load;

  i2c_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(I2C_BITS)) u_tx_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (write_enable),
    .push_data (write_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .empty     (tx_fifo_empty),
    .full      (tx_fifo_full)
  );

  i2c_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(I2C_BITS)) u_rx_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (rx_push),
    .push_data (rx_byte),
    .pop       (read_enable),
    .head      (read_data),
    .empty     (rx_fifo_empty),
    .full      (rx_fifo_full)
  );

  // Third stage of each chain is the history for edge detection.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      {scl_s1, scl_s2, scl_s3} <= 3'b111;
      {sda_s1, sda_s2, sda_s3} <= 3'b111;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_bit   <= 1'b1;
    end else begin
      scl_s1    <= scl;
      scl_s2    <= scl_s1;
      scl_s3    <= scl_s2;
      sda_s1    <= sda_in;
      sda_s2    <= sda_s1;
      sda_s3    <= sda_s2;
      scl_rise  <= scl_s2 & ~scl_s3;
      scl_fall  <= ~scl_s2 & scl_s3;
      start_det <= scl_s2 & scl_s3 & sda_s3 & ~sda_s2;
      stop_det  <= scl_s2 & scl_s3 & ~sda_s3 & sda_s2;
      sda_bit   <= sda_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      rw      <= 1'b0;
      sda_q   <= 1'b1;
      busy_q  <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      shreg   <= sh_n;
      rw      <= rw_n;
      sda_q   <= sda_n;
      busy_q  <= busy_n;
      under_q <= under_n;
      over_q  <= over_n;
    end
  end

  assign rx_byte   = {shreg[6:0], sda_bit};
  assign load_byte = tx_fifo_empty ? UNDERRUN_BYTE : tx_head;

  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    sh_n    = shreg;
    rw_n    = rw;
    sda_n   = sda_q;
    busy_n  = busy_q;
    under_n = 1'b0;
    over_n  = 1'b0;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    do_load = 1'b0;
    if (stop_det) begin
      state_n = IDLE;
      sda_n   = 1'b1;
      busy_n  = 1'b0;
    end else if (start_det) begin
      state_n = ADDR;
      cnt_n   = '0;
      sda_n   = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: if (scl_rise) begin
          sh_n  = rx_byte;
          cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (rx_byte[7:1] == SLAVE_ADDR) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
              rw_n    = rx_byte[0];
            end else begin
              state_n = WAIT_STOP;
              busy_n  = 1'b0;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            sda_n = I2C_ACK;
            cnt_n = 4'd9;
          end else if (rw) begin
            do_load = 1'b1;
          end else begin
            sda_n   = 1'b1;
            cnt_n   = '0;
            state_n = RX_BYTE;
          end
        end
        RX_BYTE: if (scl_rise) begin
          sh_n  = rx_byte;
          cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (!rx_fifo_full) begin
              rx_push = 1'b1;
              state_n = RX_ACK;
            end else begin
              over_n  = 1'b1;
              busy_n  = 1'b0;
              state_n = WAIT_STOP;
            end
          end
        end
        RX_ACK: if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            sda_n = I2C_ACK;
            cnt_n = 4'd9;
          end else begin
            sda_n   = 1'b1;
            cnt_n   = '0;
            state_n = RX_BYTE;
          end
        end
        TX_BYTE: if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            sda_n   = I2C_NACK;
            state_n = TX_ACKCHK;
          end else begin
            sda_n = shreg[6];
            sh_n  = {shreg[6:0], 1'b0};
            cnt_n = bit_cnt + 4'd1;
          end
        end
        // bit_cnt==9 marks that the master acknowledged the last byte.
        TX_ACKCHK: begin
          if (scl_rise) begin
            if (sda_bit == I2C_ACK) begin
              cnt_n = 4'd9;
            end else begin
              busy_n  = 1'b0;
              state_n = WAIT_STOP;
            end
          end else if (scl_fall && bit_cnt == 4'd9) begin
            do_load = 1'b1;
          end
        end
        WAIT_STOP: ;
        default: state_n = IDLE;
      endcase
      if (do_load) begin
        tx_pop  = !tx_fifo_empty;
        under_n = tx_fifo_empty;
        sh_n    = load_byte;
        sda_n   = load_byte[7];
        cnt_n   = 4'd1;
        state_n = TX_BYTE;
      end
    end
  end

  assign sda_out     = sda_q;
  assign busy        = busy_q;
  assign tx_underrun = under_q;
  assign rx_overrun  = over_q;

endmodule

// File: tb/tb_i2c_slave_duplex.sv
// Directed bench: bit-banged I2C master against the duplex target.
// RX FIFO is two deep so the overrun path is reachable.
module tb_i2c_slave_duplex;

  localparam int Q = 20;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic       sda_out;
  logic       write_enable = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       tx_fifo_empty, tx_fifo_full;
  logic       read_enable = 1'b0;
  logic [7:0] read_data;
  logic       rx_fifo_empty, rx_fifo_full;
  logic       tx_underrun, rx_overrun, busy;

  int checks = 0;
  int failures = 0;
  int n_under = 0;
  int n_over = 0;
  int n_low = 0;

  assign sda_in = sda_m & sda_out;

  always #5 clk = ~clk;

  i2c_slave_duplex #(.RX_DEPTH(2)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .scl           (scl),
    .sda_in        (sda_in),
    .sda_out       (sda_out),
    .write_enable  (write_enable),
    .write_data    (write_data),
    .tx_fifo_empty (tx_fifo_empty),
    .tx_fifo_full  (tx_fifo_full),
    .read_enable   (read_enable),
    .read_data     (read_data),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_full  (rx_fifo_full),
    .tx_underrun   (tx_underrun),
    .rx_overrun    (rx_overrun),
    .busy          (busy)
  );

  always @(negedge clk) begin
    if (n_rst) begin
      if (tx_underrun) n_under++;
      if (rx_overrun) n_over++;
      if (!sda_out) n_low++;
    end
  end

  typedef struct {
    logic [6:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
  } wvec_t;

  wvec_t wv [2];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_start();
    if (!scl) begin
      sda_m = 1'b1;
      tick(Q);
      scl = 1'b1;
      tick(Q);
    end
    sda_m = 1'b0;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    s = sda_in;
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(mack, s);
  endtask

  task automatic push_tx(input logic [7:0] b);
    write_data = b;
    write_enable = 1'b1;
    tick(1);
    write_enable = 1'b0;
  endtask

  task automatic pop_rx();
    read_enable = 1'b1;
    tick(1);
    read_enable = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk(name,
        {sda_out, tx_fifo_empty, tx_fifo_full, rx_fifo_empty,
         rx_fifo_full, tx_underrun, rx_overrun, busy, read_data},
        {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
  endtask

  initial begin
    logic       a;
    logic       e;
    logic [7:0] d;
    int         base;

    wv[0] = '{7'h78, 8'hA5, 8'h3C, 1'b0};
    wv[1] = '{7'h55, 8'h11, 8'h22, 1'b1};

    n_rst = 1'b0;
    tick(3);
    chk_idle("reset");
    n_rst = 1'b1;
    tick(5);

    for (int i = 0; i < 2; i++) begin
      base = n_low;
      e = !wv[i].exp_ack;
      bus_start();
      wr_byte({wv[i].addr, 1'b0}, a);
      chk("addr_ack", a, wv[i].exp_ack);
      chk("busy_mid", busy, e);
      wr_byte(wv[i].d0, a);
      chk("d0_ack", a, wv[i].exp_ack);
      wr_byte(wv[i].d1, a);
      chk("d1_ack", a, wv[i].exp_ack);
      bus_stop();
      tick(Q);
      chk("busy_end", busy, 0);
      if (e) begin
        chk("rx_d0", read_data, wv[i].d0);
        pop_rx();
        chk("rx_d1", read_data, wv[i].d1);
        pop_rx();
      end else begin
        chk("no_drive", n_low - base, 0);
        chk("tx_untouched", tx_fifo_empty, 1);
      end
      chk("rx_empty", rx_fifo_empty, 1);
    end

    push_tx(8'h12);
    push_tx(8'h34);
    base = n_under;
    bus_start();
    wr_byte(8'hF1, a);
    chk("rd_addr_ack", a, 0);
    rd_byte(1'b0, d);
    chk("rd_b0", d, 8'h12);
    rd_byte(1'b1, d);
    chk("rd_b1", d, 8'h34);
    bus_stop();
    tick(Q);
    chk("rd_tx_empty", tx_fifo_empty, 1);
    chk("rd_no_under", n_under - base, 0);
    chk("rd_busy", busy, 0);

    base = n_over;
    bus_start();
    wr_byte(8'hF0, a);
    chk("of_addr_ack", a, 0);
    wr_byte(8'h01, a);
    chk("of_ack0", a, 0);
    wr_byte(8'h02, a);
    chk("of_ack1", a, 0);
    chk("of_full", rx_fifo_full, 1);
    wr_byte(8'h03, a);
    chk("of_nack2", a, 1);
    bus_stop();
    tick(Q);
    chk("of_pulses", n_over - base, 1);
    chk("of_d0", read_data, 8'h01);
    pop_rx();
    chk("of_d1", read_data, 8'h02);
    pop_rx();
    chk("of_empty", rx_fifo_empty, 1);

    base = n_under;
    bus_start();
    wr_byte(8'hF1, a);
    chk("ur_addr_ack", a, 0);
    rd_byte(1'b1, d);
    chk("ur_byte", d, 8'hFF);
    chk("ur_pulses", n_under - base, 1);
    bus_start();
    wr_byte(8'hF0, a);
    chk("rs_addr_ack", a, 0);
    chk("rs_busy", busy, 1);
    wr_byte(8'h5A, a);
    chk("rs_ack", a, 0);
    bus_stop();
    tick(Q);
    chk("rs_data", read_data, 8'h5A);
    pop_rx();

    for (int i = 0; i < 8; i++) push_tx(8'h00);
    chk("tx_full", tx_fifo_full, 1);
    bus_start();
    wr_byte(8'hF1, a);
    chk("rr_addr_ack", a, 0);
    sda_m = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    chk("rr_driving", sda_out, 0);
    n_rst = 1'b0;
    tick(1);
    chk_idle("rr_reset");
    n_rst = 1'b1;
    tick(Q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
